// File: rtl/rr_pipe_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pipe_mux_if
//  Description : Handshake/data bundle for rr_pipe_mux. The producer side
//                (ALU result sources plus downstream ready) uses the master
//                modport; the multiplexer itself uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_pipe_mux_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = $clog2(NUM_IN)
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        select;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_src;

    modport master (
        output in_data, in_valid, mode, select, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, mode, select, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface
`default_nettype wire

// File: rtl/rr_pipe_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pipe_mux
//  Description : Registered NUM_IN-to-1 word multiplexer with per-channel
//                valid/ready. mode=0 grants the channel named by select,
//                mode=1 arbitrates round-robin across valid channels.
//                One cycle of latency, one word per cycle throughput.
//                Optional macro PIPE_MUX_COUNT_EN adds a 16-bit xfer_count
//                output counting output handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  wire logic        clk,
    input  wire logic        reset,
`ifdef PIPE_MUX_COUNT_EN
    output logic [15:0]      xfer_count,
`endif
    rr_pipe_mux_if.slave     bus
);

    localparam logic [SEL_W-1:0] c_PTR_RESET = SEL_W'(NUM_IN - 1);

    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_out_src;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_load;
    logic                w_sel_ok;
    logic                w_sel_valid;
    logic [2*NUM_IN-1:0] w_dbl;
    logic [NUM_IN-1:0]   w_rot;
    logic [NUM_IN-1:0]   w_rot_tmp;
    logic                w_rr_found;
    int                  w_rr_pos;
    logic [SEL_W-1:0]    w_rr_idx;
    logic                w_has_grant;
    logic                w_grant_valid;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [WIDTH-1:0]    w_grant_data;
    logic                w_xfer;

    // Output register can take a word when empty or draining this cycle
    assign w_load      = !r_out_valid || bus.out_ready;
    // Out-of-range selects (non-power-of-2 NUM_IN) grant nothing
    assign w_sel_ok    = int'(bus.select) < NUM_IN;
    assign w_sel_valid = |(bus.in_valid & (NUM_IN'(1) << bus.select));

    // Rotate valids so bit 0 is channel rr_ptr+1, then take the lowest set bit
    always_comb begin
        w_dbl      = {bus.in_valid, bus.in_valid};
        w_rot      = NUM_IN'(w_dbl >> (int'(r_rr_ptr) + 1));
        w_rot_tmp  = w_rot;
        w_rr_found = 1'b0;
        w_rr_pos   = 0;
        for (int j = 0; j < NUM_IN; j++) begin
            if (!w_rr_found && w_rot_tmp[0]) begin
                w_rr_found = 1'b1;
                w_rr_pos   = int'(r_rr_ptr) + 1 + j;
            end
            w_rot_tmp = w_rot_tmp >> 1;
        end
        if (w_rr_pos >= NUM_IN) begin
            w_rr_pos = w_rr_pos - NUM_IN;
        end
        w_rr_idx = SEL_W'(w_rr_pos);
    end

    // Grant decision for the current mode; explicit mode offers ready even when idle
    always_comb begin
        if (bus.mode) begin
            w_has_grant   = w_rr_found;
            w_grant_valid = w_rr_found;
            w_grant_idx   = w_rr_idx;
        end else begin
            w_has_grant   = w_sel_ok;
            w_grant_valid = w_sel_ok && w_sel_valid;
            w_grant_idx   = bus.select;
        end
    end

    // Granted channel's word and the per-channel ready vector
    always_comb begin
        w_grant_data = WIDTH'(bus.in_data >> (int'(w_grant_idx) * WIDTH));
        if (!reset && w_load && w_has_grant) begin
            bus.in_ready = NUM_IN'(1) << w_grant_idx;
        end else begin
            bus.in_ready = '0;
        end
    end

    assign w_xfer = w_grant_valid && w_load;

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= c_PTR_RESET;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_src   <= w_grant_idx;
                if (bus.mode) begin
                    r_rr_ptr <= w_grant_idx;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_src   = r_out_src;

`ifdef PIPE_MUX_COUNT_EN
    logic [15:0] r_xfer_count;

    // Count output handshakes, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_xfer_count <= '0;
        end else if (r_out_valid && bus.out_ready) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule
`default_nettype wire

// File: doc/rr_pipe_mux.md
Name: rr_pipe_mux

Overview:
Parametrised, registered N-to-1 word multiplexer with per-channel valid/ready handshakes. It supersedes the fixed 8x32 combinational select tree. It supports two modes: explicit select, and round-robin arbitration across valid inputs. It sits between the ALU functional units and the result writeback path. It provides one cycle of registered latency and full-throughput back-pressure.

Parameters:
WIDTH, 32, data word width in bits
NUM_IN, 8, number of input channels (>= 2)
SEL_W, $clog2(NUM_IN), width of select and source-index fields

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_IN  per-channel data valid
in_ready  output  NUM_IN  per-channel accept, combinational
mode  input  1  0 = explicit select, 1 = round-robin
select  input  SEL_W  channel index used when mode = 0
out_data  output  WIDTH  registered selected word
out_valid  output  1  out_data holds an untransferred word
out_ready  input  1  downstream accept
out_src  output  SEL_W  index of the channel that produced out_data

Behaviour:
- Reset values: out_valid = 0, out_data = 0, out_src = 0, internal rr_ptr = NUM_IN-1, so the first round-robin search starts at channel 0.
- load = !out_valid || out_ready. The output register accepts a new word when it is empty or being drained in the same cycle. This gives full throughput of 1 word/cycle.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N (1 cycle).
- Mode 0 (explicit select):
  - in_ready[select] = load; all other in_ready bits = 0.
  - A transfer occurs when in_valid[select] && load.
  - select >= NUM_IN (non-power-of-2 NUM_IN): no channel is granted, all in_ready = 0, and no transfer occurs.
- Mode 1 (round-robin):
  - The grant goes to the first channel with in_valid = 1, searching rr_ptr+1, rr_ptr+2, ... with modulo NUM_IN wrap-around.
  - in_ready is one-hot on the granted channel, gated by load. It is all zero if no channel is valid.
  - On a transfer, rr_ptr takes the granted index. rr_ptr is unchanged when there is no transfer.
  - rr_ptr is not updated in mode 0.
- On a transfer: out_data takes the granted channel's word, out_src takes the granted index, and out_valid = 1.
- If out_valid && out_ready with no new transfer, out_valid goes to 0. out_data and out_src hold their last values.
- If out_valid && !out_ready (stall), out_data, out_src and out_valid hold, and all in_ready = 0. The held word is unaffected by changes to mode, select or in_data during the stall.
- mode and select are sampled every cycle; a change takes effect on the next grant decision.
- At most one input transfer per cycle. in_ready never depends on out_valid of a different cycle, only on the current load.
- reset asserted mid-operation discards the held word: out_valid = 0 on the next edge, and rr_ptr returns to NUM_IN-1. While reset is high, in_ready = 0.

Optional Feature:
PIPE_MUX_COUNT_EN:
- Defined: adds output port xfer_count (16 bits). It increments by 1 on each output handshake (out_valid && out_ready), wraps from 0xFFFF to 0x0000, and is 0 at reset.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Mode 0, select=3, in_valid=8'b00001000, ch3=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_src=3; in_ready=8'b00001000 while load.
- Mode 1, all 8 channels valid continuously, ch i=i, out_ready=1 -> out_src sequence 0,1,2,...,7,0 with one word per cycle and no bubbles.
- Mode 1, only channels 2 and 5 valid, rr_ptr reset -> grants 2,5,2,5; channel 5 is never starved.
- Stall: out_valid=1 with out_ready=0 for 4 cycles while in_data changes -> out_data constant, in_ready=0; first out_ready=1 cycle drains and reloads the same edge.
- Reset mid-stall: out_valid=1, assert reset one cycle -> out_valid=0, out_data=0, next round-robin grant starts at channel 0.
- With PIPE_MUX_COUNT_EN defined, 65537 handshakes -> xfer_count=1; with NUM_IN=5, mode 0, select=6 -> no transfer, in_ready=0.
